// File: rtl/ifetcher_instsplit_if.sv
// Buffer-read and decode-issue signals of the instruction splitter.
// master = splitter side, slave = buffer/decode side.
interface ifetcher_instsplit_if #(
  parameter int IW = 32
);
  logic              iEmpty;
  logic [IW*4-1:0]   iRD;
  logic              oRE;
  logic              oValid;
  logic              iReady;
  logic [IW-1:0]     oInst;
  logic [1:0]        oSlot;

  modport master (
    input  iEmpty, iRD, iReady,
    output oRE, oValid, oInst, oSlot
  );

  modport slave (
    output iEmpty, iRD, iReady,
    input  oRE, oValid, oInst, oSlot
  );
endinterface

// File: rtl/ifetcher_instsplit.sv
// Pops 4-instruction lines from the fetch receive buffer and issues one instruction per handshake.
// Build option IFETCHER_INSTSPLIT_PREFETCH_EN pops the next line early for gap-free issue.
module ifetcher_instsplit #(
  parameter int IW = 32
) (
  input  logic                 iClk,
  input  logic                 iReset,
  input  logic                 iClear,
  input  logic [1:0]           iStartSlot,
  ifetcher_instsplit_if.master bus,
  output logic [1:0]           oState
);
  // Decode handshake: oValid is asserted only in ISSUE and does not depend on iReady;
  // oInst/oSlot are held until a cycle with oValid & iReady completes the transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2
  } stateT;

  stateT           state;
  stateT           stateNext;
  logic [IW*4-1:0] line;
  logic [1:0]      slot;
  logic [1:0]      startSlot;
  logic            xfer;
  logic            lastXfer;
  logic            popReq;
  logic            pfValid;
  logic            pfPop;

  assign xfer     = (state == ISSUE) && bus.iReady;
  assign lastXfer = xfer && (slot == 2'd3);
  assign oState   = state;

`ifdef IFETCHER_INSTSPLIT_PREFETCH_EN
  // Next line is requested while the current one still has one slot left to issue.
  assign pfPop = !pfValid &&
                 ((xfer && (slot == 2'd2)) || ((state == LOAD) && (startSlot == 2'd3)));

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      pfValid <= 1'b0;
    end else if (iClear) begin
      pfValid <= 1'b0;
    end else if (pfPop && bus.oRE) begin
      pfValid <= 1'b1;
    end else if (lastXfer) begin
      pfValid <= 1'b0;
    end
  end
`else
  assign pfValid = 1'b0;
  assign pfPop   = 1'b0;
`endif

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (!bus.iEmpty) stateNext = LOAD;
      LOAD:    stateNext = ISSUE;
      ISSUE:   if (lastXfer && !pfValid) stateNext = bus.iEmpty ? IDLE : LOAD;
      default: stateNext = IDLE;
    endcase
    if (iClear) stateNext = IDLE;
  end

  always_comb begin
    popReq     = (state == IDLE) || (lastXfer && !pfValid) || pfPop;
    bus.oRE    = popReq && !bus.iEmpty && !iClear && !iReset;
    bus.oValid = (state == ISSUE) && !iReset;
    bus.oSlot  = slot;
    case (slot)
      2'd0:    bus.oInst = line[IW-1:0];
      2'd1:    bus.oInst = line[2*IW-1:IW];
      2'd2:    bus.oInst = line[3*IW-1:2*IW];
      default: bus.oInst = line[4*IW-1:3*IW];
    endcase
  end

  // The start slot only applies to the first line loaded after a clear.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      line      <= '0;
      slot      <= '0;
      startSlot <= '0;
    end else if (iClear) begin
      startSlot <= iStartSlot;
    end else if (state == LOAD) begin
      line      <= bus.iRD;
      slot      <= startSlot;
      startSlot <= '0;
    end else if (xfer) begin
      if (slot != 2'd3) begin
        slot <= slot + 2'd1;
      end else if (pfValid) begin
        line <= bus.iRD;
        slot <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ifetcher_instsplit.sv
// Testbench for ifetcher_instsplit: buffer model plus an instruction-stream scoreboard.
module tb_ifetcher_instsplit;
  localparam int IW = 32;
  localparam int LW = IW * 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef IFETCHER_INSTSPLIT_PREFETCH_EN
  localparam int PREFETCH = 1;
`else
  localparam int PREFETCH = 0;
`endif

  // clock / reset
  logic       iClk = 1'b0;
  logic       iReset;
  logic       iClear;
  logic [1:0] iStartSlot;
  logic [1:0] dbgState;
  always #5 iClk = ~iClk;

  ifetcher_instsplit_if #(.IW(IW)) bus ();

  ifetcher_instsplit #(.IW(IW)) dut (
    .iClk       (iClk),
    .iReset     (iReset),
    .iClear     (iClear),
    .iStartSlot (iStartSlot),
    .bus        (bus),
    .oState     (dbgState)
  );

  // model state
  logic [LW-1:0]   bufQ[$];
  logic [IW+1:0]   expQ[$];
  int              compared;
  int              mismatched;
  bit              startPending;
  logic [1:0]      startVal;
  bit              holdPending;
  logic [IW+1:0]   holdVal;
  int              cycleNo;
  int              reCount, xferCount, gapCount, slot2PopCount, firstValidCycle;
  bit              anyValid;
  int              readyPat[8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic resetCounters();
    reCount = 0; xferCount = 0; gapCount = 0; slot2PopCount = 0;
    anyValid = 0; firstValidCycle = 0;
  endtask

  function automatic logic [LW-1:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // The expected stream follows the line order; a line pushed first after a clear starts at the clear's slot.
  task automatic pushLine(input logic [LW-1:0] ln);
    int start;
    start = startPending ? int'(startVal) : 0;
    startPending = 0;
    for (int s = start; s < 4; s++) expQ.push_back({2'(s), ln[s*IW +: IW]});
    bufQ.push_back(ln);
    bus.iEmpty = 1'b0;
  endtask

  task automatic tick();
    logic [IW+1:0] got;
    bit pop, clr;
    #1;
    if (bus.iEmpty || iClear || iReset) check("re_guard", bus.oRE, 0);
    pop = bus.oRE;
    clr = iClear;
    got = {bus.oSlot, bus.oInst};
    if (holdPending) begin
      check("hold_valid", bus.oValid, 1);
      check("hold_data", got, holdVal);
      holdPending = 0;
    end
    if (bus.oValid && !anyValid) begin
      anyValid = 1;
      firstValidCycle = cycleNo;
    end
    if (anyValid && !bus.oValid && expQ.size() != 0) gapCount++;
    if (pop) reCount++;
    if (bus.oValid && bus.iReady) begin
      xferCount++;
      if (pop && bus.oSlot == 2'd2) slot2PopCount++;
      check("stream_avail", expQ.size() != 0, 1);
      if (expQ.size() != 0) check("stream_data", got, expQ.pop_front());
    end else if (bus.oValid && !clr) begin
      holdPending = 1;
      holdVal = got;
    end
    @(posedge iClk);
    #1;
    if (clr) begin
      bufQ.delete();
      expQ.delete();
      startPending = 1;
      startVal = iStartSlot;
    end else if (pop && bufQ.size() != 0) begin
      bus.iRD = bufQ.pop_front();
    end
    bus.iEmpty = (bufQ.size() == 0);
    cycleNo++;
    @(negedge iClk);
  endtask

  // readyMode: 0 = always ready, 1 = fixed toggle pattern, 2 = random
  task automatic drain(input int maxCycles, input int readyMode);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.oValid) && n < maxCycles) begin
      case (readyMode)
        0:       bus.iReady = 1'b1;
        1:       bus.iReady = readyPat[n % 8] != 0;
        default: bus.iReady = $urandom_range(0, 3) != 0;
      endcase
      tick();
      n++;
    end
    check("drain_done", expQ.size(), 0);
  endtask

  task automatic waitSlot(input logic [1:0] target, input string tag);
    int n;
    n = 0;
    bus.iReady = 1'b1;
    while (!(bus.oValid && bus.oSlot == target) && n < 40) begin
      tick();
      n++;
    end
    check(tag, {bus.oValid, bus.oSlot}, {1'b1, target});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    compared = 0; mismatched = 0; cycleNo = 0;
    startPending = 0; startVal = 0; holdPending = 0; holdVal = '0;
    iReset = 1'b1; iClear = 1'b0; iStartSlot = 2'd0;
    bus.iEmpty = 1'b1; bus.iRD = '0; bus.iReady = 1'b0;
    resetCounters();
    repeat (2) @(negedge iClk);
    check("rst_valid", bus.oValid, 0);
    check("rst_re", bus.oRE, 0);
    check("rst_inst", bus.oInst, 0);
    check("rst_slot", bus.oSlot, 0);
    check("rst_state", dbgState, ST_IDLE);
    iReset = 1'b0;
    @(negedge iClk);

    // single line, always ready
    resetCounters();
    start = cycleNo;
    pushLine({32'hD3D3_0003, 32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000});
    drain(40, 0);
    check("t1_re_count", reCount, 1);
    check("t1_xfers", xferCount, 4);
    check("t1_first_lat", firstValidCycle - start, 2);
    check("t1_idle_valid", bus.oValid, 0);
    check("t1_idle_state", dbgState, ST_IDLE);

    // toggled ready
    resetCounters();
    pushLine(randLine());
    drain(60, 1);
    check("t2_xfers", xferCount, 4);
    check("t2_re_count", reCount, 1);

    // clear with start slot 2 while the buffer holds a line
    pushLine(randLine());
    iClear = 1'b1; iStartSlot = 2'd2;
    tick();
    iClear = 1'b0; iStartSlot = 2'd0;
    resetCounters();
    pushLine(randLine());
    pushLine(randLine());
    drain(60, 0);
    check("t3_xfers", xferCount, 6);

    // three queued lines streaming
    resetCounters();
    for (int i = 0; i < 3; i++) pushLine(randLine());
    drain(80, 0);
    check("t4_xfers", xferCount, 12);
    check("t4_re_count", reCount, 3);
    check("t4_gaps", gapCount, PREFETCH != 0 ? 0 : 2);
    check("t4_slot2_pops", slot2PopCount, PREFETCH != 0 ? 2 : 0);

    // clear mid-line (slot 1) and at slot 3 where a prefetch may be outstanding
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) pushLine(randLine());
      waitSlot(k == 0 ? 2'd1 : 2'd3, "t5_reach_slot");
      iClear = 1'b1;
      iStartSlot = 2'($urandom_range(0, 3));
      start = int'(iStartSlot);
      tick();
      iClear = 1'b0;
      check("t5_valid_drop", bus.oValid, 0);
      check("t5_state", dbgState, ST_IDLE);
      resetCounters();
      pushLine(randLine());
      drain(60, 0);
      check("t5_xfers", xferCount, 4 - start);
    end

    // asynchronous reset at slot 2
    pushLine(randLine());
    pushLine(randLine());
    waitSlot(2'd2, "t6_reach_slot");
    iReset = 1'b1;
    #1;
    check("t6_valid_async", bus.oValid, 0);
    check("t6_re_async", bus.oRE, 0);
    check("t6_inst_async", bus.oInst, 0);
    check("t6_slot_async", bus.oSlot, 0);
    bufQ.delete(); expQ.delete();
    startPending = 0; holdPending = 0;
    bus.iEmpty = 1'b1;
    @(negedge iClk);
    tick();
    iReset = 1'b0;
    resetCounters();
    pushLine(randLine());
    drain(40, 0);
    check("t6_xfers", xferCount, 4);

    // random traffic with occasional clears
    for (int n = 0; n < 400; n++) begin
      bus.iReady = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 39) == 0) begin
        iClear = 1'b1;
        iStartSlot = 2'($urandom_range(0, 3));
      end else if (bufQ.size() < 4 && $urandom_range(0, 3) == 0) begin
        pushLine(randLine());
      end
      tick();
      iClear = 1'b0;
    end
    drain(200, 2);
    check("rand_idle_state", dbgState, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
